aes_round_sequencer: RTL
========================

Name: aes_round_sequencer

Overview:
Top-level sequencer for the AES-128 encryption core. It accepts a cipher key and drives the round-key generator's load/expand sequence. It then accepts plaintext blocks and steps the round datapath through the pre-add, nine full rounds and the final round. It presents cur_round to both the key generator and the datapath, and holds a valid/ready result handshake at the output.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; the final round number.
KEY_CYCLES, 11, number of cycles chg_key is held high during key expansion (NUM_ROUNDS+1).
KEY_TIMEOUT, 32, maximum number of cycles to wait for key_done after expansion before flagging an error.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
key_valid  in  1  new cipher key offered
key_in  in  128  cipher key
key_ready  out  1  sequencer can accept a key
blk_valid  in  1  plaintext block offered (data is held by the datapath input register)
blk_ready  out  1  sequencer can start a block
chg_key  out  1  to key generator: load/expand key
key_out  out  128  to key generator rx_key; registered copy of the accepted key
key_done  in  1  from key generator: expansion complete
cur_round  out  4  round index to key generator and datapath
pre_add_en  out  1  datapath: load block and apply the initial AddRoundKey
round_en  out  1  datapath: execute round cur_round
final_round  out  1  datapath: skip MixColumns this round
out_valid  out  1  ciphertext valid in datapath output register
out_ready  in  1  consumer accepts ciphertext
busy  out  1  state != IDLE
key_err  out  1  sticky: key expansion timed out

Behaviour:
- Reset (async, n_rst=0, including mid-operation): state=IDLE; key_loaded=0; all outputs 0; key_out=0; cur_round=0; counters=0.
- All outputs are registered except key_ready, blk_ready and busy, which are decoded from state.
- States: IDLE, KEY_EXP, KEY_WAIT, PRE_ADD, ROUND, FINAL, OUT.
- IDLE:
  - key_ready=1.
  - blk_ready = key_loaded & ~key_valid. A key offered in the same cycle as a block takes priority.
  - key_valid: latch key_in into key_out, clear key_err and key_loaded, then go to KEY_EXP.
  - Else blk_valid & blk_ready: go to PRE_ADD.
- KEY_EXP:
  - chg_key=1 for exactly KEY_CYCLES consecutive cycles, counted 0..KEY_CYCLES-1.
  - cur_round tracks the counter value (0..10).
  - Then go to KEY_WAIT.
- KEY_WAIT:
  - chg_key=0.
  - key_done=1: set key_loaded, go to IDLE.
  - KEY_TIMEOUT cycles elapse with no key_done: set key_err, leave key_loaded=0, go to IDLE.
  - key_done on the same cycle the timeout is reached counts as success.
- PRE_ADD: one cycle; pre_add_en=1, cur_round=0. Then go to ROUND.
- ROUND:
  - round_en=1, cur_round increments 1..NUM_ROUNDS-1, one cycle each.
  - After cur_round=NUM_ROUNDS-1, go to FINAL.
- FINAL: one cycle; round_en=1, final_round=1, cur_round=NUM_ROUNDS. Then go to OUT.
- OUT:
  - out_valid=1; cur_round holds NUM_ROUNDS; round_en=0.
  - out_valid stays high until out_ready=1, then goes to IDLE.
  - out_valid must not drop without out_ready.
- Latency: block handshake in cycle 0 gives pre_add_en in cycle 1, rounds 1..9 in cycles 2..10, the final round in cycle 11, and out_valid first high in cycle 12 (NUM_ROUNDS+2).
- Throughput: minimum 13 cycles per block when out_ready is tied high (one IDLE cycle between blocks).
- Key changes are accepted only in IDLE; key_ready=0 while busy.
- A block is never started while key_loaded=0, including after a key_err.
- key_valid held high in IDLE after a completed load restarts expansion every time it is accepted. Sources must drop key_valid after the handshake.
- cur_round never exceeds NUM_ROUNDS.
- pre_add_en, round_en and chg_key are never high simultaneously.

Test Plan:
- Key load: key_in=128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, key_valid 1 cycle, key_done 2 cycles after KEY_EXP ends -> chg_key high exactly 11 cycles with cur_round 0..10, key_out equals the key, blk_ready=1 afterwards, key_err=0.
- Encrypt: after key load, blk_valid=1 with out_ready=1 -> pre_add_en at +1, round_en +2..+11, final_round only at +11 (cur_round=10), out_valid at +12 for one cycle; with datapath attached, the FIPS-197 vector gives 3925841d_02dc09fb_dc118597_196a0b32.
- Backpressure: out_ready=0 for 5 cycles -> out_valid stays 1, cur_round stays 10, blk_ready=0; out_ready=1 -> IDLE next cycle.
- Timeout: key_done never asserted -> key_err=1 exactly KEY_TIMEOUT cycles after KEY_WAIT entry, blk_ready stays 0 even with blk_valid=1; next key load clears key_err.
- Simultaneous: key_valid and blk_valid high in the same IDLE cycle -> blk_ready=0, KEY_EXP entered, no pre_add_en issued.
- Reset mid-round: n_rst=0 at cur_round=5 -> all outputs 0 asynchronously; after release blk_ready=0 until a new key completes.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: drives key expansion, then steps the datapath through
// the pre-add, nine full rounds and the final round, with a held result handshake.
//
// state    | meaning
// IDLE     | accept a new key, or start a block once a key is loaded
// KEY_EXP  | chg_key held high while cur_round counts 0..KEY_CYCLES-1
// KEY_WAIT | wait for key_done, bounded by the KEY_TIMEOUT down-counter
// PRE_ADD  | load block, initial AddRoundKey (cur_round=0)
// ROUND    | full rounds 1..NUM_ROUNDS-1
// FINAL    | last round, no MixColumns (cur_round=NUM_ROUNDS)
// OUT      | hold out_valid until out_ready
module aes_round_sequencer #(
  parameter int NUM_ROUNDS  = 10,
  parameter int KEY_CYCLES  = NUM_ROUNDS + 1,
  parameter int KEY_TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic         chg_key,
  output logic [127:0] key_out,
  input  logic         key_done,
  output logic [3:0]   cur_round,
  output logic         pre_add_en,
  output logic         round_en,
  output logic         final_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         key_err
);

  localparam int TW = $clog2(KEY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, KEY_EXP, KEY_WAIT, PRE_ADD, ROUND, FINAL, OUT
  } state_t;

  state_t        state;
  logic          key_loaded;
  logic [TW-1:0] wait_tmr;

  assign key_ready = (state == IDLE);
  assign blk_ready = (state == IDLE) & key_loaded & ~key_valid;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      key_loaded  <= 1'b0;
      key_err     <= 1'b0;
      key_out     <= '0;
      cur_round   <= '0;
      chg_key     <= 1'b0;
      pre_add_en  <= 1'b0;
      round_en    <= 1'b0;
      final_round <= 1'b0;
      out_valid   <= 1'b0;
      wait_tmr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // a key offered alongside a block wins; blk_ready is already low
          if (key_valid) begin
            state      <= KEY_EXP;
            key_out    <= key_in;
            key_err    <= 1'b0;
            key_loaded <= 1'b0;
            chg_key    <= 1'b1;
            cur_round  <= '0;
          end else if (blk_valid && blk_ready) begin
            state      <= PRE_ADD;
            pre_add_en <= 1'b1;
            cur_round  <= '0;
          end
        end
        KEY_EXP: begin
          if (cur_round == 4'(KEY_CYCLES - 1)) begin
            state     <= KEY_WAIT;
            chg_key   <= 1'b0;
            cur_round <= '0;
            wait_tmr  <= TW'(KEY_TIMEOUT - 1);
          end else begin
            cur_round <= cur_round + 4'd1;
          end
        end
        KEY_WAIT: begin
          // key_done on the terminal-count cycle still counts as success
          if (key_done) begin
            key_loaded <= 1'b1;
            state      <= IDLE;
          end else if (wait_tmr == '0) begin
            key_err <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_tmr <= wait_tmr - 1'b1;
          end
        end
        PRE_ADD: begin
          state      <= ROUND;
          pre_add_en <= 1'b0;
          round_en   <= 1'b1;
          cur_round  <= 4'd1;
        end
        ROUND: begin
          if (cur_round == 4'(NUM_ROUNDS - 1)) begin
            state       <= FINAL;
            final_round <= 1'b1;
            cur_round   <= 4'(NUM_ROUNDS);
          end else begin
            cur_round <= cur_round + 4'd1;
          end
        end
        FINAL: begin
          state       <= OUT;
          round_en    <= 1'b0;
          final_round <= 1'b0;
          out_valid   <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cur_round <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
